// File: rtl/key_pkg.sv
// Shared definitions for the key event decoder: FSM state encoding, event codes
// and the elaboration-time helper used to size the event timer.
package key_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_PRESS1    = 3'd1,
    ST_WAIT_GAP  = 3'd2,
    ST_PRESS2    = 3'd3,
    ST_HOLD_LONG = 3'd4
  } key_state_e;

  typedef enum logic [1:0] {
    EVT_NONE   = 2'd0,
    EVT_SHORT  = 2'd1,
    EVT_DOUBLE = 2'd2,
    EVT_LONG   = 2'd3
  } key_evt_e;

  // Raw key and debounced level are active-low: 1 means released.
  localparam logic LEVEL_RELEASED = 1'b1;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Two-flop synchronizer plus debouncer: the debounced level follows the
// synchronized key only after DEBOUNCE_CYCLES consecutive differing cycles.
module key_debounce
  import key_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic button_in,
  output logic level
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    sync;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync  <= {2{LEVEL_RELEASED}};
      level <= LEVEL_RELEASED;
      cnt   <= '0;
    end else begin
      sync <= {sync[0], button_in};
      if (sync[1] == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        level <= ~level;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/key_event_decoder.sv
// Classifies debounced key gestures into short press, double click and long
// press, each reported as a single registered one-cycle pulse.
//
// state        | meaning
// ST_IDLE      | released, waiting for a press
// ST_PRESS1    | first press held, timing for long press
// ST_WAIT_GAP  | released after a short press, timing the double-click gap
// ST_PRESS2    | second press held, timing for long press
// ST_HOLD_LONG | long press reported, waiting for release
module key_event_decoder
  import key_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES   = 1000000,
  parameter int unsigned DOUBLE_GAP_CYCLES = 15000000,
  parameter int unsigned LONG_CYCLES       = 50000000
) (
  input  logic CLK,
  input  logic Rstn,
  input  logic Button_In,
  output logic Pressed,
  output logic Short_Press,
  output logic Double_Click,
  output logic Long_Press
);

  localparam int unsigned TMAX = max_u(LONG_CYCLES, DOUBLE_GAP_CYCLES);
  localparam int unsigned TW   = $clog2(TMAX + 1);
  localparam logic [TW-1:0] LONG_LAST = TW'(LONG_CYCLES - 1);
  localparam logic [TW-1:0] GAP_LAST  = TW'(DOUBLE_GAP_CYCLES - 1);

  generate
    if (!(DEBOUNCE_CYCLES >= 2 && DEBOUNCE_CYCLES < DOUBLE_GAP_CYCLES &&
          DOUBLE_GAP_CYCLES < LONG_CYCLES)) begin : g_param_check
      $error("key_event_decoder: need 2 <= DEBOUNCE_CYCLES < DOUBLE_GAP_CYCLES < LONG_CYCLES");
    end
  endgenerate

  logic          deb_level;
  logic          key_down;
  logic          press_edge;
  key_state_e    state, state_next;
  key_evt_e      evt;
  logic [TW-1:0] timer;

  key_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk      (CLK),
    .rst_n    (Rstn),
    .button_in(Button_In),
    .level    (deb_level)
  );

  assign key_down = ~deb_level;
  // Pressed holds last cycle's key_down, so it doubles as the edge reference.
  assign press_edge = key_down & ~Pressed;

  always_ff @(posedge CLK or negedge Rstn) begin
    if (!Rstn) begin
      state        <= ST_IDLE;
      timer        <= '0;
      Pressed      <= 1'b0;
      Short_Press  <= 1'b0;
      Double_Click <= 1'b0;
      Long_Press   <= 1'b0;
    end else begin
      state        <= state_next;
      Pressed      <= key_down;
      Short_Press  <= (evt == EVT_SHORT);
      Double_Click <= (evt == EVT_DOUBLE);
      Long_Press   <= (evt == EVT_LONG);
      if (state_next != state) begin
        timer <= '0;
      end else if (timer != '1) begin
        timer <= timer + 1'b1;
      end
    end
  end

  always_comb begin
    state_next = state;
    evt        = EVT_NONE;
    case (state)
      ST_IDLE: begin
        if (press_edge) state_next = ST_PRESS1;
      end
      ST_PRESS1: begin
        if (!key_down) begin
          state_next = ST_WAIT_GAP;
        end else if (timer == LONG_LAST) begin
          evt        = EVT_LONG;
          state_next = ST_HOLD_LONG;
        end
      end
      ST_WAIT_GAP: begin
        // A press arriving on the expiry cycle still wins.
        if (key_down) begin
          state_next = ST_PRESS2;
        end else if (timer == GAP_LAST) begin
          evt        = EVT_SHORT;
          state_next = ST_IDLE;
        end
      end
      ST_PRESS2: begin
        if (!key_down) begin
          evt        = EVT_DOUBLE;
          state_next = ST_IDLE;
        end else if (timer == LONG_LAST) begin
          evt        = EVT_LONG;
          state_next = ST_HOLD_LONG;
        end
      end
      ST_HOLD_LONG: begin
        if (!key_down) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_key_event_decoder.sv
// Directed bench for key_event_decoder: expected Pressed edges and event pulses
// are queued with their due cycle when stimulus is driven, then matched by a monitor.
module tb_key_event_decoder;

  localparam int DEB  = 4;
  localparam int GAP  = 20;
  localparam int LONG = 50;
  // raw input change -> Pressed change: 2 sync flops, DEB stable cycles, output register
  localparam int LAT  = 2 + DEB + 1;

  typedef enum int {K_NONE, K_RISE, K_FALL, K_SHORT, K_DOUBLE, K_LONG} kind_e;
  typedef struct {
    kind_e kind;
    int    cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic button = 1'b1;
  logic pressed, short_p, dbl, lng;
  logic prev_pressed = 1'b0;

  int cyc = 0;
  int compared = 0;
  int mismatched = 0;
  exp_t sb[$];

  key_event_decoder #(
    .DEBOUNCE_CYCLES  (DEB),
    .DOUBLE_GAP_CYCLES(GAP),
    .LONG_CYCLES      (LONG)
  ) dut (
    .CLK         (clk),
    .Rstn        (rstn),
    .Button_In   (button),
    .Pressed     (pressed),
    .Short_Press (short_p),
    .Double_Click(dbl),
    .Long_Press  (lng)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic expect_evt(input kind_e k, input int at);
    exp_t e;
    e.kind = k;
    e.cyc  = at;
    sb.push_back(e);
  endtask

  task automatic check_evt(input kind_e k);
    exp_t e;
    e.kind = K_NONE;
    e.cyc  = -1;
    if (sb.size() > 0) e = sb.pop_front();
    compared++;
    assert (k === e.kind && cyc === e.cyc)
    else begin
      mismatched++;
      $error("FAIL event: observed %s at cycle %0d, expected %s at cycle %0d",
             k.name(), cyc, e.kind.name(), e.cyc);
    end
  endtask

  task automatic check_bit(input string tag, input logic got, input logic exp);
    compared++;
    assert (got === exp)
    else begin
      mismatched++;
      $error("FAIL %s: observed %b, expected %b", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (pressed !== prev_pressed) check_evt(pressed ? K_RISE : K_FALL);
    prev_pressed <= pressed;
    if ({short_p, dbl, lng} != 3'b000) begin
      compared++;
      assert ($countones({short_p, dbl, lng}) == 1)
      else begin
        mismatched++;
        $error("FAIL exclusive: observed pulses %b, expected one-hot", {short_p, dbl, lng});
      end
      check_evt(short_p ? K_SHORT : (dbl ? K_DOUBLE : K_LONG));
    end
  end

  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press_key();
    button = 1'b0;
    expect_evt(K_RISE, cyc + LAT);
  endtask

  task automatic release_key();
    button = 1'b1;
    expect_evt(K_FALL, cyc + LAT);
  endtask

  task automatic check_outputs_low(input string tag);
    check_bit({tag, "_pressed"}, pressed, 1'b0);
    check_bit({tag, "_short"},   short_p, 1'b0);
    check_bit({tag, "_double"},  dbl,     1'b0);
    check_bit({tag, "_long"},    lng,     1'b0);
  endtask

  initial begin
    int guard;
    wait_n(2);
    check_outputs_low("reset");
    rstn = 1'b1;
    wait_n(3);

    // single short press
    press_key();
    wait_n(10);
    release_key();
    expect_evt(K_SHORT, cyc + LAT + GAP);
    wait_n(45);

    // double click
    press_key();
    wait_n(10);
    release_key();
    wait_n(8);
    press_key();
    wait_n(10);
    release_key();
    expect_evt(K_DOUBLE, cyc + LAT);
    wait_n(45);

    // long press, silent release
    press_key();
    expect_evt(K_LONG, cyc + LAT + LONG);
    wait_n(80);
    release_key();
    wait_n(30);

    // bounce shorter than the debounce window
    repeat (10) begin
      button = 1'b0;
      wait_n(2);
      button = 1'b1;
      wait_n(2);
    end
    wait_n(20);
    check_bit("bounce_pressed", pressed, 1'b0);

    // reset while waiting for the double-click gap
    press_key();
    wait_n(10);
    release_key();
    wait_n(12);
    rstn = 1'b0;
    wait_n(1);
    check_outputs_low("midreset");
    wait_n(3);
    rstn = 1'b1;
    wait_n(45);

    // second press lands exactly on the gap expiry cycle
    press_key();
    wait_n(10);
    release_key();
    wait_n(GAP);
    press_key();
    wait_n(10);
    release_key();
    expect_evt(K_DOUBLE, cyc + LAT);
    wait_n(45);

    // second press one cycle after expiry: two separate short presses
    press_key();
    wait_n(10);
    release_key();
    expect_evt(K_SHORT, cyc + LAT + GAP);
    wait_n(GAP + 1);
    press_key();
    wait_n(10);
    release_key();
    expect_evt(K_SHORT, cyc + LAT + GAP);
    wait_n(45);

    guard = 0;
    while (sb.size() != 0 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    compared++;
    assert (sb.size() === 0)
    else begin
      mismatched++;
      $error("FAIL pending: observed %0d expected events still outstanding, expected 0", sb.size());
    end
    check_bit("final_pressed", pressed, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/key_event_decoder.md
KEY_EVENT_DECODER -- requirements
Module: key_event_decoder

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 1000000, is the number of consecutive stable cycles required to accept a level change (20 ms at 50 MHz).
REQ-002 Parameter DOUBLE_GAP_CYCLES, default 15000000, is the maximum debounced-release-to-press gap that counts as a double click (300 ms).
REQ-003 Parameter LONG_CYCLES, default 50000000, is the debounced hold time that counts as a long press (1 s).
REQ-004 CLK  input  1  single clock; all logic is on its rising edge.
REQ-005 Rstn  input  1  asynchronous active-low reset.
REQ-006 Button_In  input  1  raw mechanical key, active-low (0 = pressed), asynchronous to CLK.
REQ-007 Pressed  output  1  debounced key level, 1 = pressed.
REQ-008 Short_Press  output  1  one-cycle pulse: single short press completed.
REQ-009 Double_Click  output  1  one-cycle pulse: two short presses within the gap.
REQ-010 Long_Press  output  1  one-cycle pulse: hold reached LONG_CYCLES.

Function
REQ-011 Button_In SHALL pass through a 2-flop synchronizer with both flops reset to 1 (released).
REQ-012 Debounce: a counter SHALL increment while the synchronized level differs from the current debounced level, clear when they match, and toggle the debounced level when the count reaches DEBOUNCE_CYCLES-1 (change accepted after exactly DEBOUNCE_CYCLES differing cycles).
REQ-013 Pressed SHALL be registered and equal to the inverted debounced level.
REQ-014 FSM states: IDLE, PRESS1, WAIT_GAP, PRESS2, HOLD_LONG; one shared event timer cleared on every state change.
REQ-015 IDLE -> PRESS1 on the debounced press edge.
REQ-016 PRESS1: debounced release before timer reaches LONG_CYCLES-1 -> WAIT_GAP; timer reaching LONG_CYCLES-1 while pressed -> pulse Long_Press, go HOLD_LONG.
REQ-017 WAIT_GAP: debounced press before timer reaches DOUBLE_GAP_CYCLES-1 -> PRESS2; timer reaching DOUBLE_GAP_CYCLES-1 -> pulse Short_Press, go IDLE.
REQ-018 PRESS2: debounced release -> pulse Double_Click, go IDLE; timer reaching LONG_CYCLES-1 while pressed -> pulse Long_Press, go HOLD_LONG (first short press discarded, no Short_Press).
REQ-019 HOLD_LONG: no pulses; debounced release -> IDLE.
REQ-020 Event pulses SHALL be registered, exactly one cycle wide, and mutually exclusive; at most one pulse per completed gesture.
REQ-021 Simultaneous gap expiry and press edge in WAIT_GAP SHALL resolve as press (-> PRESS2).
REQ-022 Timer SHALL saturate, never wrap; width = clog2(max(LONG_CYCLES, DOUBLE_GAP_CYCLES)+1).
REQ-023 Bounce shorter than DEBOUNCE_CYCLES SHALL produce no Pressed change and no event.
REQ-024 Parameters SHALL satisfy 2 <= DEBOUNCE_CYCLES < DOUBLE_GAP_CYCLES < LONG_CYCLES; violation is flagged at elaboration.

Reset
REQ-025 On Rstn low: synchronizer and debounced level = released, counters = 0, FSM = IDLE, all outputs = 0.
REQ-026 Reset mid-gesture SHALL abandon it silently; a key held through reset release SHALL be seen as a new press after DEBOUNCE_CYCLES.

Structure
REQ-027 FSM state encoding and the event-code constants SHALL live in the shared package key_pkg.
REQ-028 Synchronizer plus debouncer SHALL be the sub-module key_debounce (Button_In in, debounced level out); FSM and timer stay in key_event_decoder.

Verification (DEBOUNCE_CYCLES=4, DOUBLE_GAP_CYCLES=20, LONG_CYCLES=50)
REQ-029 Press 10 cycles, release -> exactly one Short_Press, 20 cycles after debounced release; Pressed high 10 cycles.
REQ-030 Press 10, release 8, press 10, release -> one Double_Click on second debounced release; no Short_Press.
REQ-031 Hold 80 cycles -> Long_Press 50 cycles after debounced press; nothing on release.
REQ-032 Toggle Button_In every 2 cycles for 40 cycles, then idle high -> Pressed stays 0, no pulses.
REQ-033 Press 10, release, assert Rstn low during WAIT_GAP -> all outputs 0, no Short_Press after reset release.
REQ-034 Press 10, release, re-press exactly at gap expiry cycle -> PRESS2 taken; release -> Double_Click only.
